// File: rtl/uart_pkg.sv
// Shared UART-side APB definitions: bus widths, APB master FSM states and the response record.
package uart_pkg;

  localparam int unsigned ApbAddrWidth = 8;
  localparam int unsigned ApbDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_mst_state_e;

  typedef struct packed {
    logic [ApbDataWidth-1:0] rdata;
    logic                    err;
    logic                    timeout;
  } apb_rsp_t;

endpackage

// File: rtl/uart_apb_master.sv
// APB3 initiator: one outstanding command from a valid/ready stream, with a response channel
// carrying read data, slave error and an optional ACCESS-phase timeout.
module uart_apb_master
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ApbAddrWidth,
  parameter int unsigned DATA_WIDTH     = ApbDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk_i,
  input  logic                  presetn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  // A disabled timeout still needs a legal, non-zero counter width.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  apb_mst_state_e        state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  apb_rsp_t              rsp_q;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            pwrite_q <= cmd_write_i;
            paddr_q  <= cmd_addr_i;
            pwdata_q <= cmd_wdata_i;
            psel_q   <= 1'b1;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= CntW'(1);
          state_q   <= StAccess;
        end
        StAccess: begin
          if (pready_i) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= pwrite_q ? '0 : prdata_i;
            rsp_q.err     <= pslverr_i;
            rsp_q.timeout <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= StResp;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutVal)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= StResp;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: transaction-level model plus scripted APB slave, checked every cycle.
module tb_uart_apb_master;

  localparam int unsigned Aw = 8;
  localparam int unsigned Dw = 32;
  localparam int          To = 8;

  logic          pclk_i, presetn_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [Aw-1:0] cmd_addr_i;
  logic [Dw-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o, busy_o;
  logic [Dw-1:0] rsp_rdata_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [Aw-1:0] paddr_o;
  logic [Dw-1:0] pwdata_o, prdata_i;
  logic          pready_i, pslverr_i;

  uart_apb_master #(
    .ADDR_WIDTH    (Aw),
    .DATA_WIDTH    (Dw),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .pclk_i       (pclk_i),
    .presetn_i    (presetn_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o       (busy_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pen_cnt  = 0;

  // Slave script: wait states before pready (-1 = never), read data, error flag.
  int          s_ws    = 0;
  logic [31:0] s_rdata = 32'h0;
  bit          s_err   = 1'b0;

  // Model: m_t counts cycles since the accepting edge (1 = setup, >=2 = access cycle m_t-1).
  bit          m_busy, m_done, m_write, m_err, m_to;
  int          m_t;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    pclk_i = 1'b0;
    forever #5 pclk_i = ~pclk_i;
  end

  initial forever begin
    @(posedge pclk_i);
    cyc++;
  end

  initial forever begin
    @(posedge pclk_i or negedge presetn_i);
    if (!presetn_i) begin
      m_busy = 0; m_done = 0; m_t = 0; m_rdata = '0; m_err = 0; m_to = 0;
    end else if (!m_busy) begin
      if (cmd_valid_i) begin
        m_busy = 1; m_t = 1; m_write = cmd_write_i; m_addr = cmd_addr_i; m_wdata = cmd_wdata_i;
      end
    end else if (!m_done) begin
      if (m_t >= 2 && pready_i) begin
        m_done = 1; m_rdata = m_write ? 32'h0 : prdata_i; m_err = pslverr_i; m_to = 0;
      end else if (m_t >= 2 && To > 0 && m_t - 1 == To) begin
        m_done = 1; m_rdata = 32'h0; m_err = 1; m_to = 1;
      end else begin
        m_t++;
      end
    end else if (rsp_ready_i) begin
      m_busy = 0; m_done = 0;
    end
  end

  // Slave drives just after each edge; idle-time read data is junk the DUT must ignore.
  initial forever begin
    @(posedge pclk_i);
    #1;
    pready_i  = m_busy && !m_done && m_t >= 2 && s_ws >= 0 && (m_t - 2 >= s_ws);
    pslverr_i = pready_i && s_err;
    prdata_i  = pready_i ? s_rdata : 32'h1234_5678;
  end

  initial forever begin
    @(negedge pclk_i);
    if (penable_o) pen_cnt++;
    chk("cmd_ready", {31'b0, cmd_ready_o}, {31'b0, !m_busy});
    chk("busy", {31'b0, busy_o}, {31'b0, m_busy});
    chk("psel", {31'b0, psel_o}, {31'b0, m_busy && !m_done});
    chk("penable", {31'b0, penable_o}, {31'b0, m_busy && !m_done && m_t >= 2});
    chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_done});
    if (m_busy && !m_done) begin
      chk("paddr", {24'b0, paddr_o}, {24'b0, m_addr});
      chk("pwrite", {31'b0, pwrite_o}, {31'b0, m_write});
      if (m_write) chk("pwdata", pwdata_o, m_wdata);
    end
    if (m_done) begin
      chk("rsp_rdata", rsp_rdata_o, m_rdata);
      chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, m_err});
      chk("rsp_timeout", {31'b0, rsp_timeout_o}, {31'b0, m_to});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  // Returns the count of the edge that accepted the command.
  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d, output int acc);
    cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d; cmd_valid_i = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready_o; i++) tick();
    if (!cmd_ready_o) chk("send_ready_timeout", {31'b0, cmd_ready_o}, 32'd1);
    tick();
    acc = cyc;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int t);
    for (int i = 0; i < 40 && !rsp_valid_o; i++) tick();
    if (!rsp_valid_o) chk("rsp_wait_timeout", {31'b0, rsp_valid_o}, 32'd1);
    t = cyc;
  endtask

  int acc, acc2, t, h;

  initial begin
    presetn_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b1; pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    repeat (2) tick();
    chk("rst_psel", {31'b0, psel_o}, 32'd0);
    chk("rst_penable", {31'b0, penable_o}, 32'd0);
    chk("rst_paddr", {24'b0, paddr_o}, 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    presetn_i = 1'b1;
    tick();

    // 1: zero-wait write. Accept edge closes cycle N; rsp_valid is seen two edges later (cycle N+3).
    s_ws = 0; s_err = 0;
    send(1'b1, 8'h04, 32'h0000_00A5, acc);
    chk("t1_setup_psel", {31'b0, psel_o}, 32'd1);
    chk("t1_setup_penable", {31'b0, penable_o}, 32'd0);
    chk("t1_paddr", {24'b0, paddr_o}, 32'h04);
    chk("t1_pwdata", pwdata_o, 32'hA5);
    wait_rsp(t);
    chk("t1_latency", t - acc, 32'd2);
    chk("t1_rdata", rsp_rdata_o, 32'd0);
    chk("t1_err", {31'b0, rsp_err_o}, 32'd0);
    tick();

    // 2: read with 3 wait states.
    s_ws = 3; s_rdata = 32'hDEAD_BEEF; pen_cnt = 0;
    send(1'b0, 8'h08, 32'h0, acc);
    wait_rsp(t);
    chk("t2_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    chk("t2_err", {31'b0, rsp_err_o}, 32'd0);
    chk("t2_penable_cycles", pen_cnt, 32'd4);
    chk("t2_latency", t - acc, 32'd5);
    tick();

    // 3: slave error, then a normal write.
    s_ws = 0; s_err = 1; s_rdata = 32'h0BAD_0BAD;
    send(1'b0, 8'h0C, 32'h0, acc);
    wait_rsp(t);
    chk("t3_err", {31'b0, rsp_err_o}, 32'd1);
    chk("t3_timeout", {31'b0, rsp_timeout_o}, 32'd0);
    tick();
    s_err = 0;
    send(1'b1, 8'h10, 32'h0000_003C, acc);
    wait_rsp(t);
    chk("t3_next_err", {31'b0, rsp_err_o}, 32'd0);
    tick();

    // 4: timeout after 8 access cycles, then pready exactly on cycle 8.
    s_ws = -1; pen_cnt = 0;
    send(1'b0, 8'h14, 32'h0, acc);
    wait_rsp(t);
    chk("t4_to_timeout", {31'b0, rsp_timeout_o}, 32'd1);
    chk("t4_to_err", {31'b0, rsp_err_o}, 32'd1);
    chk("t4_to_rdata", rsp_rdata_o, 32'd0);
    chk("t4_to_penable_cycles", pen_cnt, 32'd8);
    chk("t4_to_psel_dropped", {31'b0, psel_o}, 32'd0);
    tick();
    s_ws = 7; s_rdata = 32'h600D_F00D; pen_cnt = 0;
    send(1'b0, 8'h14, 32'h0, acc);
    wait_rsp(t);
    chk("t4_edge_timeout", {31'b0, rsp_timeout_o}, 32'd0);
    chk("t4_edge_err", {31'b0, rsp_err_o}, 32'd0);
    chk("t4_edge_rdata", rsp_rdata_o, 32'h600D_F00D);
    chk("t4_edge_penable_cycles", pen_cnt, 32'd8);
    tick();

    // 5: response back-pressure with a queued command, then back-to-back throughput.
    s_ws = 0; s_rdata = 32'hCAFE_0005; rsp_ready_i = 1'b0;
    send(1'b0, 8'h18, 32'h0, acc);
    wait_rsp(t);
    cmd_write_i = 1'b1; cmd_addr_i = 8'h1C; cmd_wdata_i = 32'h77; cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
      chk("t5_hold_rdata", rsp_rdata_o, 32'hCAFE_0005);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    h = cyc;
    tick();
    acc2 = cyc;
    cmd_valid_i = 1'b0;
    chk("t5_accept_gap", acc2 - h, 32'd1);
    chk("t5_setup_psel", {31'b0, psel_o}, 32'd1);
    wait_rsp(t);
    tick();
    send(1'b1, 8'h20, 32'h11, acc);
    send(1'b0, 8'h24, 32'h0, acc2);
    chk("t5_b2b_gap", acc2 - acc, 32'd4);
    wait_rsp(t);
    tick();

    // 6: asynchronous reset during ACCESS, then a fresh read.
    s_ws = -1;
    send(1'b0, 8'h28, 32'h0, acc);
    tick();
    #2;
    presetn_i = 1'b0;
    #1;
    chk("t6_rst_psel", {31'b0, psel_o}, 32'd0);
    chk("t6_rst_penable", {31'b0, penable_o}, 32'd0);
    chk("t6_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    repeat (2) tick();
    presetn_i = 1'b1;
    chk("t6_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    s_ws = 0; s_rdata = 32'h55AA_33CC;
    send(1'b0, 8'h00, 32'h0, acc);
    wait_rsp(t);
    chk("t6_rdata", rsp_rdata_o, 32'h55AA_33CC);
    tick();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
APB initiator that turns a simple valid/ready command stream into APB3 transfers aimed at the UART controller's APB slave port.
Used by bring-up sequencers, the debug bridge, and the block-level bench to drive the UART register file with protocol-legal timing.
Only one transfer is outstanding at a time.
Each transfer returns read data and an error/timeout status on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 8, APB address width (matches the UART slave's paddr).
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles allowed without pready; 0 disables the timeout.

Ports:
- pclk_i  in  1  APB clock; single clock domain.
- presetn_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  pslverr sampled, or timeout.
- rsp_timeout_o  out  1  transfer aborted by the timeout.
- busy_o  out  1  state != IDLE.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all registered outputs are 0 (psel, penable, pwrite, paddr, pwdata, rsp_*).
  - cmd_ready_o = (state==IDLE), so it reads 1 once reset is released.
  - busy_o = 0 during reset.
- IDLE:
  - On cmd_valid_i&&cmd_ready_o, register write/addr/wdata into paddr_o, pwrite_o, pwdata_o.
  - Next state SETUP.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0. Next state ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr_o, pwrite_o and pwdata_o stay stable from SETUP until the transfer completes.
  - Wait cycle count starts at 1 on the first ACCESS cycle.
- Completion: on pready_i=1 in ACCESS:
  - Capture rsp_rdata_o = pwrite_o ? 0 : prdata_i.
  - Capture rsp_err_o = pslverr_i; rsp_timeout_o = 0.
  - Deassert psel_o and penable_o the next cycle; enter RESP.
- Timeout: TIMEOUT_CYCLES>0, cycle count == TIMEOUT_CYCLES and pready_i=0:
  - Abort the transfer: psel_o and penable_o go to 0 the next cycle.
  - rsp_rdata_o = 0, rsp_err_o = 1, rsp_timeout_o = 1; enter RESP.
  - pready_i arriving in the same cycle as the limit wins: the transfer completes normally, no timeout.
- RESP:
  - rsp_valid_o=1 with rsp_* held stable until rsp_ready_i.
  - On the handshake, rsp_valid_o=0 next cycle and state goes to IDLE.
  - Address and data outputs keep their last values; no requirement to clear them.
- Throughput:
  - Accept at cycle N gives SETUP at N+1 and ACCESS at N+2.
  - With zero-wait pready, rsp_valid_o rises at N+3.
  - With rsp_ready_i tied high, the next command is accepted at N+4 at the earliest.
- psel_o is never high outside SETUP/ACCESS; penable_o is never high without psel_o.
- Reset asserted mid-transfer:
  - Everything returns to IDLE immediately (asynchronous) with reset values.
  - No response is issued for the interrupted command.
- The timeout counter width is clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum apb_mst_state_e;
  - the response struct apb_rsp_t {rdata, err, timeout};
  - APB address/data width constants reused by uart_controller.
- No sub-modules; the timeout counter is inline.

Test Plan:
1. Write addr 0x04, wdata 0x0000_00A5, zero-wait slave -> SETUP then ACCESS with paddr=0x04, pwrite=1, pwdata=0xA5; rsp_valid 3 cycles after accept; err=0, rdata=0.
2. Read addr 0x08, slave inserts 3 wait states, returns 0xDEAD_BEEF -> penable high 4 cycles with paddr stable; rdata=0xDEADBEEF, err=0.
3. Read addr 0x0C, slave responds with pslverr=1 -> rsp_err=1, rsp_timeout=0; next command accepted normally.
4. TIMEOUT_CYCLES=8, slave never asserts pready -> psel drops after 8 ACCESS cycles; err=1, timeout=1, rdata=0. Repeat with pready on cycle 8 -> normal completion.
5. Hold rsp_ready=0 for 5 cycles while cmd_valid is high -> cmd_ready stays 0, rsp fields stable, no new SETUP; next accept occurs 1 cycle after the response handshake.
6. Assert presetn_i low during ACCESS -> psel, penable and rsp_valid go to 0 asynchronously; after release cmd_ready=1 and a fresh read of 0x00 completes.
